// File: rtl/pwm_measure_pkg.sv
// pwm_measure_pkg: state encoding shared by the PWM measurement block.
package pwm_measure_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;
endpackage

// File: rtl/pwm_measure_sync.sv
// sync_edge_detect: synchronizes an async input and flags its rising/falling edges.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end
  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;
endmodule

// File: rtl/pwm_measure.sv
// pwm_measure: measures high time and period of an async PWM input in clock cycles.
module pwm_measure
  import pwm_measure_pkg::*;
#(
  parameter int COUNT_WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   pwm_i,
  output logic [COUNT_WIDTH-1:0] high_count_o,
  output logic [COUNT_WIDTH-1:0] period_count_o,
  output logic                   meas_valid_o,
  output logic                   level_stuck_o,
  output logic                   stuck_level_o
);
  localparam logic [COUNT_WIDTH-1:0] MAX = '1;
  logic sync, rise, fall;
  state_e state_q, state_d;
  logic [COUNT_WIDTH-1:0] ctr_q, ctr_d, high_lat_q, high_lat_d;
  logic [COUNT_WIDTH-1:0] high_q, high_d, period_q, period_d;
  logic valid_q, valid_d, stuck_q, stuck_d, stuck_lvl_q, stuck_lvl_d;
  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (pwm_i),
    .sync_o  (sync),
    .rise_o  (rise),
    .fall_o  (fall)
  );
  always_comb begin
    state_d     = state_q;
    ctr_d       = rise ? COUNT_WIDTH'(1) : (ctr_q == MAX ? ctr_q : ctr_q + 1'b1);
    high_lat_d  = high_lat_q;
    high_d      = high_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    stuck_d     = stuck_q;
    stuck_lvl_d = stuck_lvl_q;
    case (state_q)
      IDLE: if (rise) begin
        state_d = HIGH;
        stuck_d = 1'b0;
      end
      HIGH: if (fall) begin
        high_lat_d = ctr_q;
        state_d    = LOW;
      end else if (ctr_q == MAX) begin
        state_d     = IDLE;
        stuck_d     = 1'b1;
        stuck_lvl_d = sync;
      end
      LOW: if (rise) begin
        high_d   = high_lat_q;
        period_d = ctr_q;
        valid_d  = 1'b1;
        state_d  = HIGH;
      end else if (ctr_q == MAX) begin
        state_d     = IDLE;
        stuck_d     = 1'b1;
        stuck_lvl_d = sync;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ctr_q       <= '0;
      high_lat_q  <= '0;
      high_q      <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      stuck_q     <= 1'b0;
      stuck_lvl_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      high_lat_q  <= high_lat_d;
      high_q      <= high_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      stuck_q     <= stuck_d;
      stuck_lvl_q <= stuck_lvl_d;
    end
  end
  assign high_count_o   = high_q;
  assign period_count_o = period_q;
  assign meas_valid_o   = valid_q;
  assign level_stuck_o  = stuck_q;
  assign stuck_level_o  = stuck_lvl_q;
endmodule
